// File: rtl/store_unit.sv
// Store path to the data-memory write port: aligns store data into byte lanes and issues
// one or two write beats (two when the store crosses a word boundary), stalling while busy.
//
// state | meaning
// IDLE  | waiting for a store request
// BEAT1 | first (or only) beat on the bus, held until dm_ready_in
// BEAT2 | second beat of a word-crossing store, held until dm_ready_in
module store_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        st_req_in,
    input  logic [31:0] rs2_in,
    input  logic [31:0] iadder_in,
    input  logic [1:0]  store_size_in,
    input  logic        dm_ready_in,
    output logic        dm_wr_req_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_data_o,
    output logic [3:0]  dm_wr_mask_o,
    output logic        st_busy_o,
    output logic        st_done_o,
    output logic        misaligned_o
);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;

    state_t      state_q, state_d;
    logic [3:0]  mask_hi_q, mask_hi_d;
    logic        two_beat_q, two_beat_d;
    logic        req_d, done_d, mis_d;
    logic [31:0] addr_d, data_d;
    logic [3:0]  mask_d;

    logic [3:0]  base_mask;
    logic [7:0]  mask8;
    logic [31:0] rot_data;
    logic        split;

    // Lane alignment of the incoming request; only consumed on acceptance in IDLE.
    always_comb begin
        base_mask = 4'b1111;
        case (store_size_in)
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
        mask8 = {4'b0000, base_mask} << iadder_in[1:0];
        split = |mask8[7:4];
        rot_data = rs2_in;
        case (iadder_in[1:0])
            2'd0: rot_data = rs2_in;
            2'd1: rot_data = {rs2_in[23:0], rs2_in[31:24]};
            2'd2: rot_data = {rs2_in[15:0], rs2_in[31:16]};
            2'd3: rot_data = {rs2_in[7:0],  rs2_in[31:8]};
        endcase
    end

    always_comb begin
        state_d    = state_q;
        mask_hi_d  = mask_hi_q;
        two_beat_d = two_beat_q;
        req_d      = dm_wr_req_o;
        addr_d     = dm_addr_o;
        data_d     = dm_data_o;
        mask_d     = dm_wr_mask_o;
        done_d     = 1'b0;
        mis_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (st_req_in) begin
                    if (split && !ALLOW_MISALIGNED) begin
                        mis_d = 1'b1;
                    end else begin
                        state_d    = BEAT1;
                        req_d      = 1'b1;
                        addr_d     = {iadder_in[31:2], 2'b00};
                        data_d     = rot_data;
                        mask_d     = mask8[3:0];
                        mask_hi_d  = mask8[7:4];
                        two_beat_d = split;
                    end
                end
            end
            BEAT1: begin
                if (dm_ready_in) begin
                    if (two_beat_q) begin
                        state_d = BEAT2;
                        addr_d  = dm_addr_o + 32'd4;
                        mask_d  = mask_hi_q;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            BEAT2: begin
                if (dm_ready_in) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            mask_hi_q    <= 4'b0000;
            two_beat_q   <= 1'b0;
            dm_wr_req_o  <= 1'b0;
            dm_addr_o    <= 32'd0;
            dm_data_o    <= 32'd0;
            dm_wr_mask_o <= 4'b0000;
            st_busy_o    <= 1'b0;
            st_done_o    <= 1'b0;
            misaligned_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_hi_q    <= mask_hi_d;
            two_beat_q   <= two_beat_d;
            dm_wr_req_o  <= req_d;
            dm_addr_o    <= addr_d;
            dm_data_o    <= data_d;
            dm_wr_mask_o <= mask_d;
            st_busy_o    <= (state_d != IDLE);
            st_done_o    <= done_d;
            misaligned_o <= mis_d;
        end
    end

endmodule
